// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate in both directions, parallel load, clear,
// with a frame counter that strobes frame_done after every WIDTH-th shift.
module universal_shift_register #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              CW          = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic [CW-1:0]    count,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             frame_done_q, frame_done_d;
    logic             shift_op;
    logic             restart_frame;

    always_comb begin
        q_d           = q_q;
        shift_op      = 1'b0;
        restart_frame = 1'b0;
        if (enable) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], serial_in};
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {serial_in, q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_d           = parallel_in;
                    restart_frame = 1'b1;
                end
                MODE_CLEAR: begin
                    q_d           = '0;
                    restart_frame = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Load/clear discard any partial frame without a strobe.
    always_comb begin
        count_d      = count_q;
        frame_done_d = 1'b0;
        if (restart_frame) begin
            count_d = '0;
        end else if (shift_op) begin
            if (count_q == LAST_BIT) begin
                count_d      = '0;
                frame_done_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q          <= RESET_VALUE;
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign q              = q_q;
    assign count          = count_q;
    assign frame_done     = frame_done_q;
    assign serial_out_msb = q_q[WIDTH-1];
    assign serial_out_lsb = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: the driver queues hand-computed
// expectations, a monitor compares them after each clock edge.
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] RV = 8'h3C;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [2:0]       mode;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] q;
    logic             serial_out_msb;
    logic             serial_out_lsb;
    logic [CW-1:0]    count;
    logic             frame_done;

    universal_shift_register #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .serial_in      (serial_in),
        .parallel_in    (parallel_in),
        .q              (q),
        .serial_out_msb (serial_out_msb),
        .serial_out_lsb (serial_out_lsb),
        .count          (count),
        .frame_done     (frame_done)
    );

    typedef struct {
        string            nm;
        logic [WIDTH-1:0] q;
        logic [CW-1:0]    c;
        logic             fd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clocked operation; expectation describes state after the next rising edge.
    task automatic step(input string nm, input logic en, input logic [2:0] md, input logic sin,
                        input logic [WIDTH-1:0] pin, input logic [WIDTH-1:0] eq,
                        input logic [CW-1:0] ec, input logic efd);
        exp_t e;
        @(negedge clk);
        enable      = en;
        mode        = md;
        serial_in   = sin;
        parallel_in = pin;
        e.nm = nm; e.q = eq; e.c = ec; e.fd = efd;
        sb.push_back(e);
    endtask

    // Reset pulse placed between edges; state must change without a clock edge.
    task automatic reset_pulse(input string nm);
        @(negedge clk);
        enable = 1'b0;
        mode   = 3'b000;
        #2 reset = 1'b1;
        #1;
        check({nm, "_q"}, 32'(q), 32'(RV));
        check({nm, "_count"}, 32'(count), 32'd0);
        check({nm, "_fd"}, 32'(frame_done), 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.nm, "_q"}, 32'(q), 32'(e.q));
                check({e.nm, "_count"}, 32'(count), 32'(e.c));
                check({e.nm, "_fd"}, 32'(frame_done), 32'(e.fd));
                check({e.nm, "_msb"}, 32'(serial_out_msb), 32'(e.q[WIDTH-1]));
                check({e.nm, "_lsb"}, 32'(serial_out_lsb), 32'(e.q[0]));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset       = 1'b1;
        enable      = 1'b0;
        mode        = 3'b000;
        serial_in   = 1'b0;
        parallel_in = '0;
        #7;
        check("reset_q", 32'(q), 32'(RV));
        check("reset_count", 32'(count), 32'd0);
        check("reset_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Async reset from a loaded, mid-frame state
        step("ar_load", 1, 3'b101, 0, 8'hFF, 8'hFF, 0, 0);
        step("ar_shl",  1, 3'b001, 0, 8'h00, 8'hFE, 1, 0);
        reset_pulse("ar_async");

        // Deserialise 1,0,1,1,0,0,1,0 starting from RESET_VALUE
        step("ds1", 1, 3'b001, 1, 8'h00, 8'h79, 1, 0);
        step("ds2", 1, 3'b001, 0, 8'h00, 8'hF2, 2, 0);
        step("ds3", 1, 3'b001, 1, 8'h00, 8'hE5, 3, 0);
        step("ds4", 1, 3'b001, 1, 8'h00, 8'hCB, 4, 0);
        step("ds5", 1, 3'b001, 0, 8'h00, 8'h96, 5, 0);
        step("ds6", 1, 3'b001, 0, 8'h00, 8'h2C, 6, 0);
        step("ds7", 1, 3'b001, 1, 8'h00, 8'h59, 7, 0);
        step("ds8", 1, 3'b001, 0, 8'h00, 8'hB2, 0, 1);
        step("ds_hold", 1, 3'b000, 1, 8'h00, 8'hB2, 0, 0);

        // Rotate
        step("rot_load", 1, 3'b101, 0, 8'h81, 8'h81, 0, 0);
        step("rol1",     1, 3'b011, 0, 8'h00, 8'h03, 1, 0);
        step("rol2",     1, 3'b011, 1, 8'h00, 8'h06, 2, 0);
        step("rot_load2",1, 3'b101, 0, 8'h81, 8'h81, 0, 0);
        step("ror1",     1, 3'b100, 1, 8'h00, 8'hC0, 1, 0);

        // Enable gating, then counting resumes from the held value
        for (int i = 0; i < 5; i++)
            step("gate", 0, 3'b001, 1, 8'hAA, 8'hC0, 1, 0);
        step("resume1", 1, 3'b001, 1, 8'h00, 8'h81, 2, 0);
        step("resume2", 1, 3'b001, 0, 8'h00, 8'h02, 3, 0);
        step("resume3", 1, 3'b001, 0, 8'h00, 8'h04, 4, 0);
        step("resume4", 1, 3'b001, 0, 8'h00, 8'h08, 5, 0);
        step("resume5", 1, 3'b001, 0, 8'h00, 8'h10, 6, 0);
        step("resume6", 1, 3'b001, 0, 8'h00, 8'h20, 7, 0);
        step("resume7", 1, 3'b001, 0, 8'h00, 8'h40, 0, 1);

        // Abort by load
        step("ab_s1", 1, 3'b001, 1, 8'h00, 8'h81, 1, 0);
        step("ab_s2", 1, 3'b001, 1, 8'h00, 8'h03, 2, 0);
        step("ab_s3", 1, 3'b001, 1, 8'h00, 8'h07, 3, 0);
        step("ab_load", 1, 3'b101, 1, 8'h5A, 8'h5A, 0, 0);
        step("ab_r1", 1, 3'b010, 0, 8'h00, 8'h2D, 1, 0);
        step("ab_r2", 1, 3'b010, 0, 8'h00, 8'h16, 2, 0);
        step("ab_r3", 1, 3'b010, 0, 8'h00, 8'h0B, 3, 0);
        step("ab_r4", 1, 3'b010, 0, 8'h00, 8'h05, 4, 0);
        step("ab_r5", 1, 3'b010, 0, 8'h00, 8'h02, 5, 0);
        step("ab_r6", 1, 3'b010, 0, 8'h00, 8'h01, 6, 0);
        step("ab_r7", 1, 3'b010, 0, 8'h00, 8'h00, 7, 0);
        step("ab_r8", 1, 3'b010, 0, 8'h00, 8'h00, 0, 1);
        step("ab_hold", 1, 3'b000, 0, 8'h00, 8'h00, 0, 0);

        // Abort by reset
        step("rs_s1", 1, 3'b001, 1, 8'h00, 8'h01, 1, 0);
        step("rs_s2", 1, 3'b001, 1, 8'h00, 8'h03, 2, 0);
        step("rs_s3", 1, 3'b001, 1, 8'h00, 8'h07, 3, 0);
        reset_pulse("rs_async");
        step("rs_r1", 1, 3'b010, 1, 8'h00, 8'h9E, 1, 0);
        step("rs_r2", 1, 3'b010, 1, 8'h00, 8'hCF, 2, 0);
        step("rs_r3", 1, 3'b010, 1, 8'h00, 8'hE7, 3, 0);
        step("rs_r4", 1, 3'b010, 1, 8'h00, 8'hF3, 4, 0);
        step("rs_r5", 1, 3'b010, 1, 8'h00, 8'hF9, 5, 0);
        step("rs_r6", 1, 3'b010, 1, 8'h00, 8'hFC, 6, 0);
        step("rs_r7", 1, 3'b010, 1, 8'h00, 8'hFE, 7, 0);
        step("rs_r8", 1, 3'b010, 1, 8'h00, 8'hFF, 0, 1);

        // Clear goes to zero, not RESET_VALUE
        step("clear", 1, 3'b110, 1, 8'hAA, 8'h00, 0, 0);

        // Back-to-back frames with reserved mode and hold mid-frame
        step("bb1",  1, 3'b001, 1, 8'h00, 8'h01, 1, 0);
        step("bb2",  1, 3'b001, 1, 8'h00, 8'h03, 2, 0);
        step("bb3",  1, 3'b001, 1, 8'h00, 8'h07, 3, 0);
        step("bb4",  1, 3'b001, 1, 8'h00, 8'h0F, 4, 0);
        step("bb5",  1, 3'b001, 1, 8'h00, 8'h1F, 5, 0);
        step("bb6",  1, 3'b001, 1, 8'h00, 8'h3F, 6, 0);
        step("bb7",  1, 3'b001, 1, 8'h00, 8'h7F, 7, 0);
        step("bb8",  1, 3'b001, 1, 8'h00, 8'hFF, 0, 1);
        step("bb9",  1, 3'b001, 0, 8'h00, 8'hFE, 1, 0);
        step("bb10", 1, 3'b001, 0, 8'h00, 8'hFC, 2, 0);
        step("bb11", 1, 3'b001, 0, 8'h00, 8'hF8, 3, 0);
        step("bb_m7",   1, 3'b111, 1, 8'h55, 8'hF8, 3, 0);
        step("bb_hold", 1, 3'b000, 1, 8'h55, 8'hF8, 3, 0);
        step("bb12", 1, 3'b001, 0, 8'h00, 8'hF0, 4, 0);
        step("bb13", 1, 3'b001, 0, 8'h00, 8'hE0, 5, 0);
        step("bb14", 1, 3'b001, 0, 8'h00, 8'hC0, 6, 0);
        step("bb15", 1, 3'b001, 0, 8'h00, 8'h80, 7, 0);
        step("bb16", 1, 3'b001, 0, 8'h00, 8'h00, 0, 1);
        step("bb_end", 0, 3'b001, 1, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register with a per-cycle enable, a selectable operation mode and a built-in frame counter. It generalises the team's fixed 4-bit serial-in register to any width, and adds bidirectional shift, rotate, parallel load and clear. It sits between serial peripheral pins and parallel datapath logic: it deserialises incoming bit streams with a word-complete strobe, and it serialises parallel words.

## Interface
- `WIDTH`, default 8: register width in bits; legal range ≥ 2.
- `RESET_VALUE`, default 0: value loaded into `q` on reset; `WIDTH` bits.
- `CW`, default `$clog2(WIDTH)+1`: width of `count`; derived, not overridden.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `enable`  in  1: when low, all state holds and `frame_done` is 0.
- `mode`  in  3: operation select (see Operation).
- `serial_in`  in  1: bit shifted into the vacated position.
- `parallel_in`  in  `WIDTH`: word for parallel load.
- `q`  out  `WIDTH`: register contents, registered.
- `serial_out_msb`  out  1: `q[WIDTH-1]`, combinational from `q`.
- `serial_out_lsb`  out  1: `q[0]`, combinational from `q`.
- `count`  out  `CW`: number of shift/rotate operations in the current frame, range 0..`WIDTH-1`.
- `frame_done`  out  1: one-cycle strobe that the frame has completed, registered.

## Operation
Modes apply only on a rising `clk` edge with `enable`=1:
- **000 hold:** `q` unchanged.
- **001 shift left:** `q <= {q[WIDTH-2:0], serial_in}`. The first bit in reaches the MSB after `WIDTH` shifts.
- **010 shift right:** `q <= {serial_in, q[WIDTH-1:1]}`.
- **011 rotate left:** `q <= {q[WIDTH-2:0], q[WIDTH-1]}`. `serial_in` is ignored.
- **100 rotate right:** `q <= {q[0], q[WIDTH-1:1]}`.
- **101 parallel load:** `q <= parallel_in`.
- **110 clear:** `q <= 0`. This clears to zero, not to `RESET_VALUE`.
- **111:** reserved; behaves as hold.

Frame counter:
- Modes 001–100 count as shift operations.
- On a shift operation, if `count` == `WIDTH-1`, then `count` <= 0 and `frame_done` <= 1.
- On any other shift operation, `count` <= `count`+1 and `frame_done` <= 0.
- Load (101) and clear (110) set `count` <= 0 and `frame_done` <= 0. This discards any partial frame and produces no strobe.
- Hold, reserved mode or `enable`=0: `count` unchanged and `frame_done` <= 0.

Reset:
- `reset`=1 forces `q`=`RESET_VALUE`, `count`=0 and `frame_done`=0 immediately, with no clock edge required.
- Reset mid-frame aborts the frame; no strobe is issued.
- While `reset` is high, all inputs are ignored.
- The first edge after `reset` deasserts operates normally.

## Timing
- `q` latency is 1 cycle: a new value is visible after the edge that samples `mode`, `serial_in` and `parallel_in`.
- `frame_done` is high for exactly the one cycle after the edge performing the `WIDTH`-th shift. It coincides with `q` holding the complete word, so a consumer samples `q` while `frame_done`=1.
- Back-to-back frames need no gap; the next shift after the strobe is counted as frame bit 0.
- `serial_out_*` follow `q` combinationally, so there is no extra latency.
- The first bit of a serial frame is valid at `serial_out_msb` the cycle after the load.
- Inputs must be stable around the `clk` rising edge; reset deassertion is synchronised externally.

## Test plan
- **Async reset:** load 8'hFF, then pulse `reset` between edges. `q`=`RESET_VALUE`, `count`=0 and `frame_done`=0 must change before the next edge.
- **Deserialise:** 8 × mode 001 with `serial_in` = 1,0,1,1,0,0,1,0. After the 8th edge `q`=8'hB2, `frame_done`=1 for exactly one cycle and `count`=0. `count` reads 1..7 after edges 1–7.
- **Rotate:** load 8'h81, then rotate left gives 8'h03, then rotate left again gives 8'h06. Separately, from 8'h81, rotate right gives 8'hC0. `frame_done` stays 0 throughout.
- **Enable gating:** with `mode`=001 and `enable`=0 for 5 cycles, `q` and `count` are unchanged and `frame_done`=0. Set `enable`=1 and resume: counting continues from the held value.
- **Abort by load/reset:** after 3 shifts, load 8'h5A. `count`=0, no strobe, and `q`=8'h5A. Then 8 × shift right with `serial_in`=0: `q`=8'h00 and the strobe occurs on the 8th edge. Repeat the test with `reset` after 3 shifts: no strobe.
- **Back-to-back frames and mode 111:** 16 consecutive shifts give strobes after edges 8 and 16. Mode 111 mid-frame holds both `q` and `count`.
